// File: rtl/addr_region_checker_pkg.sv
// Shared types and pure helpers for the address region checker.
// Region bounds are stored at the widest supported XLEN and zero-extended.
package addr_region_checker_pkg;

  localparam int ADDR_MAX_W = 64;
  localparam int IALIGN_16  = 16;
  localparam int IALIGN_32  = 32;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef struct packed {
    logic [ADDR_MAX_W-1:0] base;
    logic [ADDR_MAX_W-1:0] limit;
    logic                  en;
    logic                  lock;
  } region_cfg_t;

  function automatic logic x_in_range(input region_cfg_t r, input logic [ADDR_MAX_W-1:0] addr);
    return r.en && (r.base <= addr) && (addr <= r.limit);
  endfunction

  function automatic logic misaligned(input logic [2:0] lo, input logic fetch,
                                      input logic [1:0] size, input int ialign,
                                      input int xlen);
    logic m;
    if (fetch) begin
      m = (ialign == IALIGN_32) ? (lo[1:0] != 2'b00) : lo[0];
    end else begin
      case (size)
        SIZE_B:  m = 1'b0;
        SIZE_H:  m = lo[0];
        SIZE_W:  m = (lo[1:0] != 2'b00);
        default: m = (xlen == 32) ? 1'b1 : (lo != 3'b000);
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/addr_region_checker_region_match.sv
// Combinational per-region compare and lowest-index priority encoder.
module addr_region_checker_region_match
  import addr_region_checker_pkg::*;
#(
  parameter int REGION_NUM = 4,
  parameter int IDX_W      = 2
) (
  input  region_cfg_t                 regions [REGION_NUM],
  input  logic [ADDR_MAX_W-1:0]       addr,
  output logic                        hit,
  output logic [IDX_W-1:0]            idx
);

  logic [REGION_NUM-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < REGION_NUM; i++) begin
      match[i] = x_in_range(regions[i], addr);
    end
  end

  // Scan high to low so the lowest matching index is the last one written.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = REGION_NUM - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/addr_region_checker.sv
// Registered address region / alignment checker with valid/ready handshake
// and a saturating debug fault counter.
module addr_region_checker
  import addr_region_checker_pkg::*;
#(
  parameter int REGION_NUM = 4,
  parameter int XLEN       = 32,
  parameter int IALIGN     = 32,
  parameter int CNT_W      = 16,
  localparam int IDX_W     = (REGION_NUM > 1) ? $clog2(REGION_NUM) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [XLEN-1:0]  cfg_base,
  input  logic [XLEN-1:0]  cfg_limit,
  input  logic             cfg_en,
  input  logic             cfg_lock,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [XLEN-1:0]  req_addr,
  input  logic             req_fetch,
  input  logic [1:0]       req_size,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_hit,
  output logic [IDX_W-1:0] resp_idx,
  output logic             resp_misaligned,
  output logic             resp_fault,
  output logic [CNT_W-1:0] fault_cnt,
  input  logic             fault_cnt_clr
);

  region_cfg_t      regions [REGION_NUM];
  logic             match_hit;
  logic [IDX_W-1:0] match_idx;
  logic             mis_now;
  logic             accept;

  assign req_ready = ~resp_valid | resp_ready;
  assign accept    = req_valid & req_ready;
  assign mis_now   = misaligned(req_addr[2:0], req_fetch, req_size, IALIGN, XLEN);

  addr_region_checker_region_match #(
    .REGION_NUM (REGION_NUM),
    .IDX_W      (IDX_W)
  ) u_match (
    .regions (regions),
    .addr    (ADDR_MAX_W'(req_addr)),
    .hit     (match_hit),
    .idx     (match_idx)
  );

  // An out-of-range cfg_idx never equals any loop index, so it is dropped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < REGION_NUM; i++) regions[i] <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < REGION_NUM; i++) begin
        if (cfg_idx == IDX_W'(i) && !regions[i].lock) begin
          regions[i] <= '{base:  ADDR_MAX_W'(cfg_base),
                          limit: ADDR_MAX_W'(cfg_limit),
                          en:    cfg_en,
                          lock:  cfg_lock};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      resp_valid      <= 1'b0;
      resp_hit        <= 1'b0;
      resp_idx        <= '0;
      resp_misaligned <= 1'b0;
      resp_fault      <= 1'b0;
    end else if (accept) begin
      resp_valid      <= 1'b1;
      resp_hit        <= match_hit;
      resp_idx        <= match_idx;
      resp_misaligned <= mis_now;
      resp_fault      <= mis_now | ~match_hit;
    end else if (resp_ready) begin
      resp_valid      <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || fault_cnt_clr) begin
      fault_cnt <= '0;
    end else if (resp_valid && resp_ready && resp_fault && (fault_cnt != '1)) begin
      fault_cnt <= fault_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_addr_region_checker.sv
// Directed bench: two checker instances (IALIGN 32/CNT_W 16 and IALIGN 16/CNT_W 2)
// share stimulus and are compared every cycle against a behavioural model.
module tb_addr_region_checker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [31:0] cfg_base = '0, cfg_limit = '0;
  logic        cfg_en = 1'b0, cfg_lock = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_fetch = 1'b0;
  logic [1:0]  req_size = '0;
  logic        resp_ready = 1'b1;
  logic        fault_cnt_clr = 1'b0;

  logic        rdy_a, val_a, hit_a, mis_a, flt_a;
  logic [1:0]  idx_a;
  logic [15:0] cnt_a;
  logic        rdy_b, val_b, hit_b, mis_b, flt_b;
  logic [1:0]  idx_b;
  logic [1:0]  cnt_b;

  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;

  always #5 clk = ~clk;

  addr_region_checker #(.REGION_NUM(4), .XLEN(32), .IALIGN(32), .CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_base(cfg_base), .cfg_limit(cfg_limit), .cfg_en(cfg_en), .cfg_lock(cfg_lock),
    .req_valid(req_valid), .req_ready(rdy_a), .req_addr(req_addr),
    .req_fetch(req_fetch), .req_size(req_size), .resp_valid(val_a),
    .resp_ready(resp_ready), .resp_hit(hit_a), .resp_idx(idx_a),
    .resp_misaligned(mis_a), .resp_fault(flt_a), .fault_cnt(cnt_a),
    .fault_cnt_clr(fault_cnt_clr));

  addr_region_checker #(.REGION_NUM(4), .XLEN(32), .IALIGN(16), .CNT_W(2)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_base(cfg_base), .cfg_limit(cfg_limit), .cfg_en(cfg_en), .cfg_lock(cfg_lock),
    .req_valid(req_valid), .req_ready(rdy_b), .req_addr(req_addr),
    .req_fetch(req_fetch), .req_size(req_size), .resp_valid(val_b),
    .resp_ready(resp_ready), .resp_hit(hit_b), .resp_idx(idx_b),
    .resp_misaligned(mis_b), .resp_fault(flt_b), .fault_cnt(cnt_b),
    .fault_cnt_clr(fault_cnt_clr));

  // ---------------- behavioural model ----------------
  longint unsigned m_base [4], m_limit [4];
  bit              m_en [4], m_lock [4];
  bit              e_valid, e_hit;
  int              e_idx;
  bit              e_mis [2];
  int              e_cnt [2];
  int              cnt_cap [2] = '{65535, 3};
  int              ialign [2]  = '{32, 16};

  function automatic bit mis_model(longint unsigned a, bit fetch, int size, int ia);
    if (fetch) return (a % (ia / 8)) != 0;
    if (size == 3) return 1'b1;
    return (a % (1 << size)) != 0;
  endfunction

  always @(posedge clk) begin
    bit acc, hs, found;
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        m_base[i] = 0; m_limit[i] = 0; m_en[i] = 0; m_lock[i] = 0;
      end
      e_valid = 0; e_hit = 0; e_idx = 0; e_mis = '{0, 0}; e_cnt = '{0, 0};
    end else begin
      acc = req_valid && (!e_valid || resp_ready);
      hs  = e_valid && resp_ready;
      for (int k = 0; k < 2; k++) begin
        if (fault_cnt_clr) e_cnt[k] = 0;
        else if (hs && (e_mis[k] || !e_hit) && e_cnt[k] < cnt_cap[k]) e_cnt[k]++;
      end
      if (acc) begin
        found = 0;
        e_idx = 0;
        for (int i = 0; i < 4; i++) begin
          if (!found && m_en[i] && m_base[i] <= req_addr && req_addr <= m_limit[i]) begin
            found = 1; e_idx = i;
          end
        end
        e_hit = found;
        for (int k = 0; k < 2; k++) e_mis[k] = mis_model(req_addr, req_fetch, req_size, ialign[k]);
        e_valid = 1;
      end else if (hs) begin
        e_valid = 0;
      end
      if (cfg_we && !m_lock[cfg_idx]) begin
        m_base[cfg_idx] = cfg_base; m_limit[cfg_idx] = cfg_limit;
        m_en[cfg_idx] = cfg_en; m_lock[cfg_idx] = cfg_lock;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("a.req_ready", rdy_a, !e_valid || resp_ready);
      chk("b.req_ready", rdy_b, !e_valid || resp_ready);
      chk("a.resp_valid", val_a, e_valid);
      chk("b.resp_valid", val_b, e_valid);
      chk("a.fault_cnt", cnt_a, e_cnt[0]);
      chk("b.fault_cnt", cnt_b, e_cnt[1]);
      if (e_valid) begin
        chk("a.hit", hit_a, e_hit);
        chk("b.hit", hit_b, e_hit);
        chk("a.idx", idx_a, e_idx);
        chk("b.idx", idx_b, e_idx);
        chk("a.mis", mis_a, e_mis[0]);
        chk("b.mis", mis_b, e_mis[1]);
        chk("a.fault", flt_a, e_mis[0] || !e_hit);
        chk("b.fault", flt_b, e_mis[1] || !e_hit);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int idx, input logic [31:0] b, input logic [31:0] l,
                     input bit en, input bit lk);
    cfg_we = 1; cfg_idx = 2'(idx); cfg_base = b; cfg_limit = l; cfg_en = en; cfg_lock = lk;
    tick();
    cfg_we = 0;
  endtask

  task automatic req(input logic [31:0] a, input bit f, input int sz);
    req_valid = 1; req_addr = a; req_fetch = f; req_size = 2'(sz);
    tick();
    req_valid = 0;
  endtask

  initial begin
    reset_n = 0;
    tick(); tick();
    armed = 1;
    chk("rst.valid", val_a, 0);
    chk("rst.cnt", cnt_a, 0);
    reset_n = 1;

    cfg(0, 32'h8000_0000, 32'h8000_FFFF, 1, 0);
    req(32'h8000_0100, 1, 0);
    chk("basic.valid", val_a, 1);
    chk("basic.hit", hit_a, 1);
    chk("basic.idx", idx_a, 0);
    chk("basic.mis", mis_a, 0);
    chk("basic.fault", flt_a, 0);
    tick();
    chk("basic.drain", val_a, 0);

    cfg(1, 32'h8000_0000, 32'h8FFF_FFFF, 1, 0);
    req(32'h8000_0000, 0, 2);
    chk("ovl.idx0", idx_a, 0);
    req(32'h8001_0000, 0, 2);
    chk("ovl.idx1", idx_a, 1);
    req(32'h7FFF_FFFC, 0, 2);
    chk("ovl.miss", hit_a, 0);
    chk("ovl.fault", flt_a, 1);
    tick();
    chk("ovl.cnt", cnt_a, 1);

    req(32'h8000_0002, 1, 0);
    chk("al.i32", mis_a, 1);
    chk("al.i16", mis_b, 0);
    req(32'h8000_0006, 0, 2);
    chk("al.w", mis_a, 1);
    req(32'h8000_0007, 0, 0);
    chk("al.b", mis_a, 0);
    req(32'h8000_0000, 0, 3);
    chk("al.d32", mis_a, 1);
    req(32'h8000_0001, 0, 1);
    chk("al.h", mis_b, 1);
    tick();

    cfg(2, 32'h0000_1000, 32'h0000_1FFF, 1, 1);
    cfg(2, 32'h0000_1000, 32'h0000_1FFF, 0, 0);
    req(32'h0000_1800, 0, 0);
    chk("lock.hit", hit_a, 1);
    chk("lock.idx", idx_a, 2);
    tick();
    reset_n = 0;
    tick();
    reset_n = 1;
    req(32'h0000_1800, 0, 0);
    chk("lock.rst", hit_a, 0);
    tick();
    cfg(2, 32'h0000_1000, 32'h0000_1FFF, 1, 0);
    req(32'h0000_1800, 0, 0);
    chk("lock.rewr", hit_a, 1);
    tick();

    resp_ready = 0;
    req_valid = 1; req_addr = 32'h0000_1004; req_fetch = 0; req_size = 2'd2;
    tick();
    chk("bp.valid", val_a, 1);
    req_addr = 32'h0000_3000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp.ready", rdy_a, 0);
      chk("bp.hold.hit", hit_a, 1);
      chk("bp.hold.idx", idx_a, 2);
    end
    resp_ready = 1;
    cfg_we = 1; cfg_idx = 2'd3; cfg_base = 32'h0000_3000; cfg_limit = 32'h0000_3FFF;
    cfg_en = 1; cfg_lock = 0;
    tick();
    cfg_we = 0;
    chk("bp.oldcfg.valid", val_a, 1);
    chk("bp.oldcfg.hit", hit_a, 0);
    tick();
    chk("bp.newcfg.hit", hit_a, 1);
    chk("bp.newcfg.idx", idx_a, 3);
    req_valid = 0;
    tick();

    fault_cnt_clr = 1;
    tick();
    fault_cnt_clr = 0;
    chk("cnt.clr0", cnt_a, 0);
    req_valid = 1; req_addr = 32'h9000_0000; req_size = 2'd0;
    for (int i = 0; i < 5; i++) tick();
    req_valid = 0;
    tick();
    chk("cnt.a5", cnt_a, 5);
    chk("cnt.bsat", cnt_b, 3);
    req(32'h9000_0000, 0, 0);
    fault_cnt_clr = 1;
    tick();
    fault_cnt_clr = 0;
    chk("cnt.clrpri.a", cnt_a, 0);
    chk("cnt.clrpri.b", cnt_b, 0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addr_region_checker.md
# addr_region_checker

Registered address checker: generalises the single-range/IALIGN helper functions into N programmable regions with per-region lock, selectable instruction alignment and access-size alignment, behind a valid/ready request/response pair. It sits between the fetch/LSU address generation and the memory interface, flagging misaligned and out-of-region accesses one cycle after acceptance. Also keeps a saturating fault counter for debug.

## Interface
- REGION_NUM, 4, number of regions (1..16)
- XLEN, 32, address/data width (32 or 64)
- IALIGN, 32, instruction alignment in bits (16 or 32)
- CNT_W, 16, fault counter width
- clk  in  1  clock
- reset_n  in  1  synchronous reset, active low
- cfg_we  in  1  region config write strobe
- cfg_idx  in  $clog2(REGION_NUM) (min 1)  region written
- cfg_base  in  XLEN  inclusive lower bound
- cfg_limit  in  XLEN  inclusive upper bound
- cfg_en  in  1  region enable
- cfg_lock  in  1  lock region until reset
- req_valid  in  1  check request valid
- req_ready  out  1  request accepted when valid&ready
- req_addr  in  XLEN  address
- req_fetch  in  1  1 = instruction fetch, 0 = data
- req_size  in  2  data size log2 bytes (0..3; 3 legal only if XLEN=64)
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts result
- resp_hit  out  1  address in some enabled region
- resp_idx  out  $clog2(REGION_NUM) (min 1)  lowest-index hit region, 0 if no hit
- resp_misaligned  out  1  alignment violation
- resp_fault  out  1  misaligned | ~hit
- fault_cnt  out  CNT_W  saturating count of faulting responses
- fault_cnt_clr  in  1  clear fault_cnt

## Operation
- Region i hits when en_i & base_i <= addr & addr <= limit_i (unsigned, full XLEN compare). base > limit → never hits.
- Priority: lowest index wins for resp_idx.
- Alignment: fetch with IALIGN=32 → addr[1:0] must be 0; IALIGN=16 → addr[0] must be 0. Data: low req_size bits must be 0 (size 0 never misaligned). req_size=3 with XLEN=32 → misaligned=1.
- Config write: if region cfg_idx lock bit is 0, base/limit/en/lock updated at the edge; if locked, write ignored entirely. cfg_idx ≥ REGION_NUM ignored.
- Check computed at acceptance from register state before that edge: a config write in the same cycle as acceptance does not affect that request.
- fault_cnt increments by 1 on each response handshake (resp_valid&resp_ready) with resp_fault=1; saturates at all-ones. fault_cnt_clr has priority over increment (result 0).

## Timing
- Reset (reset_n=0 at edge): all regions en=0, lock=0, base=limit=0; resp_valid=0, resp_hit=0, resp_idx=0, resp_misaligned=0, resp_fault=0, fault_cnt=0. Reset overrides everything including an in-flight result, which is dropped.
- req_ready = ~resp_valid | resp_ready (combinational, single output register, no skid).
- Latency 1: request accepted at edge t → result visible with resp_valid=1 after edge t.
- Result fields hold stable while resp_valid & ~resp_ready.
- Back-to-back: with resp_ready held 1, one request per cycle, full throughput.
- resp_valid falls after a handshake edge with no new request accepted.

## Structure
- Shared package: region config struct (base, limit, en, lock), IALIGN legal values, size encoding constants; ialigned/x_in_range-style pure functions extended with IALIGN and size arguments.
- One sub-module natural: region_match (purely combinational, per-region compare vector + priority encoder to idx/hit), instantiated once.

## Test plan
- Reset, program region0 0x8000_0000..0x8000_FFFF en; check fetch 0x8000_0100 → resp_valid next cycle, hit=1, idx=0, misaligned=0, fault=0, fault_cnt=0.
- Overlap: region1 0x8000_0000..0x8FFF_FFFF, region0 as above; addr 0x8000_0000 → idx=0; addr 0x8001_0000 → idx=1; addr 0x7FFF_FFFC → hit=0, fault=1, fault_cnt=1 after handshake.
- Alignment: IALIGN=16 fetch 0x8000_0002 → misaligned=0; IALIGN=32 same → misaligned=1; data size=2 addr 0x8000_0006 → misaligned=1; size=0 any addr → 0.
- Lock: write region2 en with lock=1, then rewrite with en=0 → region2 still hits; after reset_n pulse region2 disabled and writable.
- Backpressure: resp_ready=0 for 3 cycles with req_valid=1 → req_ready=0, result stable; release → one handshake per cycle thereafter; same-cycle cfg write + accept uses old config.
- Counter: CNT_W=2, 5 faulting handshakes → fault_cnt=3; clr with simultaneous fault → 0.
